// File: rtl/bp_pkg.sv
// Shared branch-predictor types: checkpoint entry layout, direction encoding
// and the default queue geometry.
package bp_pkg;

  localparam int BQ_DEPTH   = 8;
  localparam int BQ_PC_W    = 32;
  localparam int BQ_GHIST_W = 8;
  localparam int BQ_NCOMP   = 2;
  localparam int BQ_PTR_W   = $clog2(BQ_DEPTH);

  typedef enum logic {
    NOT_TAKEN = 1'b0,
    TAKEN     = 1'b1
  } br_dir_e;

  typedef struct packed {
    logic [BQ_PC_W-1:0]    pc;
    logic [BQ_GHIST_W-1:0] ghist;
    br_dir_e               pred;
    logic [BQ_NCOMP-1:0]   comp;
    logic [BQ_PC_W-1:0]    alt_pc;
  } bq_entry_t;

  // Bit i is set when component predictor i agreed with the actual outcome.
  function automatic logic [BQ_NCOMP-1:0] comp_agree(input logic [BQ_NCOMP-1:0] comp,
                                                     input logic taken);
    comp_agree = ~(comp ^ {BQ_NCOMP{taken}});
  endfunction

endpackage

// File: rtl/bq_storage.sv
// Checkpoint register file: one synchronous write port, one asynchronous
// read port used for the queue head. Contents are intentionally not reset.
module bq_storage
  import bp_pkg::*;
#(
  parameter int DEPTH = BQ_DEPTH,
  localparam int PTR_W = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             we_i,
  input  logic [PTR_W-1:0] waddr_i,
  input  bq_entry_t        wdata_i,
  input  logic [PTR_W-1:0] raddr_i,
  output bq_entry_t        rdata_o
);

  bq_entry_t mem_q [DEPTH];

  // Entry write
  always_ff @(posedge clk) begin
    if (we_i) begin
      mem_q[waddr_i] <= wdata_i;
    end
  end

  assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/branch_checkpoint_queue.sv
// In-order queue of branch prediction checkpoints: resolves mispredicts at
// commit, redirects the front end and emits a registered training packet.
module branch_checkpoint_queue
  import bp_pkg::*;
#(
  parameter int DEPTH   = BQ_DEPTH,
  parameter int PC_W    = BQ_PC_W,
  parameter int GHIST_W = BQ_GHIST_W,
  parameter int NCOMP   = BQ_NCOMP
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       alloc_valid,
  output logic                       alloc_ready,
  input  logic [PC_W-1:0]            alloc_pc,
  input  logic [GHIST_W-1:0]         alloc_ghist,
  input  logic                       alloc_pred,
  input  logic [NCOMP-1:0]           alloc_comp,
  input  logic [PC_W-1:0]            alloc_alt_pc,
  input  logic                       commit_valid,
  input  logic                       commit_taken,
  input  logic                       ext_flush,
  output logic                       mispredict,
  output logic [PC_W-1:0]            recovery_pc,
  output logic                       upd_valid,
  output logic [PC_W-1:0]            upd_pc,
  output logic [GHIST_W-1:0]         upd_ghist,
  output logic                       upd_taken,
  output logic [NCOMP-1:0]           upd_comp_ok,
  output logic [$clog2(DEPTH):0]     count,
  output logic                       err_overflow,
  output logic                       err_underflow
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam logic [PTR_W-1:0] PTR_ONE   = {{(PTR_W-1){1'b0}}, 1'b1};
  localparam logic [CNT_W-1:0] CNT_ONE   = {{(CNT_W-1){1'b0}}, 1'b1};
  localparam logic [CNT_W-1:0] CNT_DEPTH = CNT_W'(DEPTH);

  logic [PTR_W-1:0]   wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d, rd_next_s;
  logic [CNT_W-1:0]   count_q, count_d;
  logic               err_ovf_q, err_ovf_d, err_unf_q, err_unf_d;
  logic               upd_valid_q, upd_valid_d, upd_taken_q, upd_taken_d;
  logic [PC_W-1:0]    upd_pc_q, upd_pc_d;
  logic [GHIST_W-1:0] upd_ghist_q, upd_ghist_d;
  logic [NCOMP-1:0]   upd_comp_ok_q, upd_comp_ok_d;

  logic      empty_s, full_s, alloc_acc_s, do_commit_s, mispredict_s, we_s;
  bq_entry_t head_s, wentry_s;

  assign empty_s      = (count_q == {CNT_W{1'b0}});
  assign full_s       = (count_q == CNT_DEPTH);
  assign alloc_acc_s  = alloc_valid & ~full_s;
  assign do_commit_s  = commit_valid & ~empty_s;
  assign mispredict_s = do_commit_s & (commit_taken != head_s.pred);
  assign rd_next_s    = rd_ptr_q + PTR_ONE;
  // Wrong-path allocs arriving alongside a squash never land in storage.
  assign we_s         = alloc_acc_s & ~mispredict_s & ~ext_flush;

  assign wentry_s.pc     = alloc_pc;
  assign wentry_s.ghist  = alloc_ghist;
  assign wentry_s.pred   = br_dir_e'(alloc_pred);
  assign wentry_s.comp   = alloc_comp;
  assign wentry_s.alt_pc = alloc_alt_pc;

  bq_storage #(.DEPTH(DEPTH)) u_storage (
    .clk     (clk),
    .we_i    (we_s),
    .waddr_i (wr_ptr_q),
    .wdata_i (wentry_s),
    .raddr_i (rd_ptr_q),
    .rdata_o (head_s)
  );

  // Pointer, occupancy, error and training-packet next state
  always_comb begin
    wr_ptr_d      = wr_ptr_q;
    rd_ptr_d      = rd_ptr_q;
    count_d       = count_q;
    err_ovf_d     = err_ovf_q | (alloc_valid & full_s & ~mispredict_s);
    err_unf_d     = err_unf_q | (commit_valid & empty_s);
    upd_valid_d   = do_commit_s;
    upd_pc_d      = upd_pc_q;
    upd_ghist_d   = upd_ghist_q;
    upd_taken_d   = upd_taken_q;
    upd_comp_ok_d = upd_comp_ok_q;
    if (do_commit_s) begin
      rd_ptr_d      = rd_next_s;
      upd_pc_d      = head_s.pc;
      upd_ghist_d   = head_s.ghist;
      upd_taken_d   = commit_taken;
      upd_comp_ok_d = comp_agree(head_s.comp, commit_taken);
    end else begin
      rd_ptr_d = rd_ptr_q;
    end
    if (mispredict_s || ext_flush) begin
      wr_ptr_d = rd_ptr_d;
      count_d  = {CNT_W{1'b0}};
    end else begin
      if (alloc_acc_s) begin
        wr_ptr_d = wr_ptr_q + PTR_ONE;
      end else begin
        wr_ptr_d = wr_ptr_q;
      end
      if (alloc_acc_s && !do_commit_s) begin
        count_d = count_q + CNT_ONE;
      end else if (!alloc_acc_s && do_commit_s) begin
        count_d = count_q - CNT_ONE;
      end else begin
        count_d = count_q;
      end
    end
  end

  // State registers with synchronous active-low reset
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr_q      <= {PTR_W{1'b0}};
      rd_ptr_q      <= {PTR_W{1'b0}};
      count_q       <= {CNT_W{1'b0}};
      err_ovf_q     <= 1'b0;
      err_unf_q     <= 1'b0;
      upd_valid_q   <= 1'b0;
      upd_pc_q      <= {PC_W{1'b0}};
      upd_ghist_q   <= {GHIST_W{1'b0}};
      upd_taken_q   <= 1'b0;
      upd_comp_ok_q <= {NCOMP{1'b0}};
    end else begin
      wr_ptr_q      <= wr_ptr_d;
      rd_ptr_q      <= rd_ptr_d;
      count_q       <= count_d;
      err_ovf_q     <= err_ovf_d;
      err_unf_q     <= err_unf_d;
      upd_valid_q   <= upd_valid_d;
      upd_pc_q      <= upd_pc_d;
      upd_ghist_q   <= upd_ghist_d;
      upd_taken_q   <= upd_taken_d;
      upd_comp_ok_q <= upd_comp_ok_d;
    end
  end

  assign alloc_ready   = ~full_s;
  assign mispredict    = mispredict_s;
  assign recovery_pc   = mispredict_s ? head_s.alt_pc : {PC_W{1'b0}};
  assign upd_valid     = upd_valid_q;
  assign upd_pc        = upd_pc_q;
  assign upd_ghist     = upd_ghist_q;
  assign upd_taken     = upd_taken_q;
  assign upd_comp_ok   = upd_comp_ok_q;
  assign count         = count_q;
  assign err_overflow  = err_ovf_q;
  assign err_underflow = err_unf_q;

endmodule

// File: tb/tb_branch_checkpoint_queue.sv
// Randomized scoreboard bench for branch_checkpoint_queue against a queue-based
// reference model of the checkpoint FIFO.
module tb_branch_checkpoint_queue;

  localparam int DEPTH = 8;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        alloc_valid = 1'b0, alloc_ready, alloc_pred = 1'b0;
  logic [31:0] alloc_pc = 32'h0, alloc_alt_pc = 32'h0;
  logic [7:0]  alloc_ghist = 8'h0;
  logic [1:0]  alloc_comp = 2'b00;
  logic        commit_valid = 1'b0, commit_taken = 1'b0, ext_flush = 1'b0;
  logic        mispredict, upd_valid, upd_taken, err_overflow, err_underflow;
  logic [31:0] recovery_pc, upd_pc;
  logic [7:0]  upd_ghist;
  logic [1:0]  upd_comp_ok;
  logic [3:0]  count;

  branch_checkpoint_queue dut (
    .clk(clk), .rst_n(rst_n),
    .alloc_valid(alloc_valid), .alloc_ready(alloc_ready), .alloc_pc(alloc_pc),
    .alloc_ghist(alloc_ghist), .alloc_pred(alloc_pred), .alloc_comp(alloc_comp),
    .alloc_alt_pc(alloc_alt_pc), .commit_valid(commit_valid), .commit_taken(commit_taken),
    .ext_flush(ext_flush), .mispredict(mispredict), .recovery_pc(recovery_pc),
    .upd_valid(upd_valid), .upd_pc(upd_pc), .upd_ghist(upd_ghist), .upd_taken(upd_taken),
    .upd_comp_ok(upd_comp_ok), .count(count), .err_overflow(err_overflow),
    .err_underflow(err_underflow)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] pc;
    logic [7:0]  gh;
    logic        pred;
    logic [1:0]  comp;
    logic [31:0] alt;
  } ent_t;

  typedef struct {
    logic [31:0] pc;
    logic [7:0]  gh;
    logic        tk;
    logic [1:0]  ok;
    int          due;
  } upd_t;

  ent_t        mq[$];
  upd_t        eq[$];
  bit          m_of = 1'b0, m_uf = 1'b0;
  int          cyc = 0;
  int          pass_cnt = 0, total_cnt = 0;
  bit          force_alt = 1'b0;
  logic [31:0] forced_alt = 32'h0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [63:0] got, input logic [63:0] exp);
    total_cnt++;
    if (got === exp) pass_cnt++;
    else $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, got, exp, cyc);
  endtask

  function automatic bit head_pred();
    return (mq.size() > 0) ? mq[0].pred : 1'b0;
  endfunction

  // Monitor: every training pulse must match the oldest outstanding expectation, on time.
  always @(negedge clk) begin : mon
    upd_t u;
    if (upd_valid === 1'b1) begin
      if (eq.size() == 0) begin
        chk("upd_spurious", 64'(upd_valid), 64'd0);
      end else begin
        u = eq.pop_front();
        chk("upd_latency", 64'(cyc), 64'(u.due));
        chk("upd_pc", 64'(upd_pc), 64'(u.pc));
        chk("upd_ghist", 64'(upd_ghist), 64'(u.gh));
        chk("upd_taken", 64'(upd_taken), 64'(u.tk));
        chk("upd_comp_ok", 64'(upd_comp_ok), 64'(u.ok));
      end
    end else if (eq.size() > 0 && eq[0].due <= cyc) begin
      u = eq.pop_front();
      chk("upd_missing", 64'(upd_valid), 64'd1);
    end
  end

  // One clock of stimulus; the model advances from the pre-edge state.
  task automatic step(input bit av, input bit pred, input bit cv, input bit ct, input bit fl);
    ent_t e;
    upd_t u;
    bit   dc, mp, was_full;
    e.pc   = $urandom();
    e.gh   = 8'($urandom());
    e.pred = pred;
    e.comp = 2'($urandom());
    e.alt  = force_alt ? forced_alt : (pred ? e.pc + 32'd4 : $urandom());
    alloc_valid = av; alloc_pc = e.pc; alloc_ghist = e.gh; alloc_pred = e.pred;
    alloc_comp = e.comp; alloc_alt_pc = e.alt;
    commit_valid = cv; commit_taken = ct; ext_flush = fl;
    @(negedge clk);
    was_full = (mq.size() == DEPTH);
    dc = cv && (mq.size() > 0);
    mp = dc && (ct != mq[0].pred);
    chk("count", 64'(count), 64'(mq.size()));
    chk("alloc_ready", 64'(alloc_ready), 64'(!was_full));
    chk("mispredict", 64'(mispredict), 64'(mp));
    chk("recovery_pc", 64'(recovery_pc), mp ? 64'(mq[0].alt) : 64'd0);
    chk("err_overflow", 64'(err_overflow), 64'(m_of));
    chk("err_underflow", 64'(err_underflow), 64'(m_uf));
    if (dc) begin
      u.pc = mq[0].pc; u.gh = mq[0].gh; u.tk = ct; u.due = cyc + 1;
      for (int i = 0; i < 2; i++) u.ok[i] = (mq[0].comp[i] == ct);
      eq.push_back(u);
      void'(mq.pop_front());
    end
    if (cv && !dc) m_uf = 1'b1;
    if (av && was_full && !mp) m_of = 1'b1;
    if (mp || fl) mq.delete();
    else if (av && !was_full) mq.push_back(e);
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    alloc_valid = 1'b0; commit_valid = 1'b0; ext_flush = 1'b0;
    @(negedge clk);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    mq.delete(); eq.delete(); m_of = 1'b0; m_uf = 1'b0;
    chk("rst_count", 64'(count), 64'd0);
    chk("rst_upd_valid", 64'(upd_valid), 64'd0);
    chk("rst_alloc_ready", 64'(alloc_ready), 64'd1);
    chk("rst_err_overflow", 64'(err_overflow), 64'd0);
    chk("rst_err_underflow", 64'(err_underflow), 64'd0);
  endtask

  initial begin
    do_reset();
    // three branches, all predicted correctly
    step(1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
    step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    step(1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
    step(1'b0, 1'b0, 1'b1, 1'b1, 1'b0);
    step(1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
    step(1'b0, 1'b0, 1'b1, 1'b1, 1'b0);
    idle(2);
    // mispredicted head with recovery to 0x104, three younger entries
    force_alt = 1'b1; forced_alt = 32'h0000_0104;
    step(1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
    force_alt = 1'b0;
    for (int i = 0; i < 3; i++) step(1'b1, 1'($urandom()), 1'b0, 1'b0, 1'b0);
    step(1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
    idle(1);
    // mispredict with a same-cycle alloc
    step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    step(1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
    step(1'b1, 1'b1, 1'b1, 1'b1, 1'b0);
    idle(1);
    // commit while empty: sticky underflow
    step(1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
    idle(2);
    // fill, overflow, then commit+alloc at count 7
    do_reset();
    for (int i = 0; i < DEPTH; i++) step(1'b1, 1'($urandom()), 1'b0, 1'b0, 1'b0);
    step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    step(1'b0, 1'b0, 1'b1, head_pred(), 1'b0);
    step(1'b1, 1'($urandom()), 1'b1, head_pred(), 1'b0);
    idle(2);
    // external flush with five entries and a same-cycle commit
    do_reset();
    for (int i = 0; i < 5; i++) step(1'b1, 1'($urandom()), 1'b0, 1'b0, 1'b0);
    step(1'b1, 1'b0, 1'b1, head_pred(), 1'b1);
    idle(2);
    // pointer wrap: 20 alloc/commit pairs
    step(1'b1, 1'($urandom()), 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 20; i++) step(1'b1, 1'($urandom()), 1'b1, head_pred(), 1'b0);
    step(1'b0, 1'b0, 1'b1, head_pred(), 1'b0);
    idle(1);
    // randomized traffic
    do_reset();
    for (int i = 0; i < 400; i++) begin
      bit av, cv, ct, fl;
      av = ($urandom_range(0, 99) < 60);
      cv = ($urandom_range(0, 99) < 45);
      ct = ($urandom_range(0, 99) < 80) ? head_pred() : 1'($urandom());
      fl = ($urandom_range(0, 99) < 3);
      step(av, 1'($urandom()), cv, ct, fl);
    end
    idle(2);
    // reset with entries in flight
    do_reset();
    for (int i = 0; i < 3; i++) step(1'b1, 1'($urandom()), 1'b0, 1'b0, 1'b0);
    do_reset();
    idle(3);
    chk("scoreboard_drained", 64'(eq.size()), 64'd0);
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
